// File: rtl/seq_pkg.sv
// Shared definitions for the serializer front end and the sequence detector benches.
package seq_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned SER_WIDTH   = 8;
    localparam logic [3:0]  DET_PATTERN = 4'b1011;

endpackage

// File: rtl/ser_pend_buf.sv
// One-entry pending word register for bit_serializer, with full flag and ready decode.
module ser_pend_buf
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             ready_o
);

    logic             full_d, full_q;
    logic             en_d, en_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        en_d   = 1'b1;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    // en_q keeps ready low during reset and raises it on the first edge after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            en_q   <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign data_o  = data_q;
    assign full_o  = full_q;
    assign ready_o = en_q & ~full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: streams WIDTH-bit words onto x one bit per clock, gap-free.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    ser_state_e       state_d, state_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic [WIDTH-1:0] sreg_d, sreg_q;
    logic             x_d, x_q;
    logic             xv_d, xv_q;
    logic             fs_d, fs_q;

    logic             accept, last, load;
    logic [WIDTH-1:0] load_word;
    logic             pend_push, pend_pop, pend_full, pend_ready;
    logic [WIDTH-1:0] pend_data;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept    = din_valid & pend_ready;
    assign last      = (state_q == SER_SHIFT) && (cnt_q == LAST);
    assign pend_pop  = last & pend_full;
    // On the last bit with an empty buffer the incoming word bypasses straight to the shifter.
    assign pend_push = accept & (state_q == SER_SHIFT) & ~last;

    ser_pend_buf #(
        .WIDTH (WIDTH)
    ) u_pend (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (pend_push),
        .pop_i   (pend_pop),
        .data_i  (din),
        .data_o  (pend_data),
        .full_o  (pend_full),
        .ready_o (pend_ready)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        x_d       = x_q;
        xv_d      = xv_q;
        fs_d      = fs_q;
        load      = 1'b0;
        load_word = '0;
        unique case (state_q)
            SER_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    load_word = din;
                end
            end
            SER_SHIFT: begin
                if (last) begin
                    if (pend_full) begin
                        load      = 1'b1;
                        load_word = pend_data;
                    end else if (accept) begin
                        load      = 1'b1;
                        load_word = din;
                    end else begin
                        state_d = SER_IDLE;
                        cnt_d   = '0;
                        x_d     = IDLE_BIT;
                        xv_d    = 1'b0;
                        fs_d    = 1'b0;
                    end
                end else begin
                    x_d    = head(sreg_q);
                    sreg_d = tail(sreg_q);
                    cnt_d  = cnt_q + CW'(1);
                    fs_d   = 1'b0;
                end
            end
        endcase
        // The first bit goes straight to x; the shifter keeps the remaining bits.
        if (load) begin
            state_d = SER_SHIFT;
            cnt_d   = '0;
            x_d     = head(load_word);
            sreg_d  = tail(load_word);
            xv_d    = 1'b1;
            fs_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            x_q     <= IDLE_BIT;
            xv_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign x_valid     = xv_q;
    assign frame_start = fs_q;
    assign busy        = (state_q == SER_SHIFT) | pend_full;
    assign din_ready   = pend_ready;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances plus a 1011 detector model.
module tb_bit_serializer;
    import seq_pkg::*;

    localparam int unsigned W    = SER_WIDTH;
    localparam logic        IDLE = 1'b0;

    typedef struct packed {
        logic x;
        logic fs;
    } exp_t;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] din_m   = '0;
    logic [W-1:0] din_l   = '0;
    logic         dv_m    = 1'b0;
    logic         dv_l    = 1'b0;
    logic         rdy_m, x_m, xv_m, fs_m, busy_m;
    logic         rdy_l, x_l, xv_l, fs_l, busy_l;

    exp_t q_m[$];
    exp_t q_l[$];
    exp_t em, el;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] det_hist = '0;
    logic       det_hit;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_m (
        .clk         (clk),
        .reset       (reset_n),
        .din         (din_m),
        .din_valid   (dv_m),
        .din_ready   (rdy_m),
        .x           (x_m),
        .x_valid     (xv_m),
        .frame_start (fs_m),
        .busy        (busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_l (
        .clk         (clk),
        .reset       (reset_n),
        .din         (din_l),
        .din_valid   (dv_l),
        .din_ready   (rdy_l),
        .x           (x_l),
        .x_valid     (xv_l),
        .frame_start (fs_l),
        .busy        (busy_l)
    );

    // Behavioural stand-in for the downstream detector, fed from the MSB-first x.
    always @(posedge clk) det_hist <= {det_hist[2:0], x_m};
    assign det_hit = (det_hist == DET_PATTERN);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // sel 0 = MSB-first instance, sel 1 = LSB-first instance.
    task automatic push_word(input bit sel, input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < int'(W); i++) begin
            e.x  = sel ? w[i] : w[W-1-i];
            e.fs = (i == 0);
            if (sel) q_l.push_back(e);
            else     q_m.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [W-1:0] w, output int waits);
        logic r;
        waits = 0;
        if (sel) begin din_l = w; dv_l = 1'b1; end
        else     begin din_m = w; dv_m = 1'b1; end
        for (int k = 0; k < 100; k++) begin
            r = sel ? rdy_l : rdy_m;
            @(posedge clk);
            if (r) begin
                push_word(sel, w);
                @(negedge clk);
                return;
            end
            @(negedge clk);
            waits++;
        end
        check_eq("send_ready_timeout", {31'd0, sel ? rdy_l : rdy_m}, 1);
    endtask

    task automatic count_run(input bit sel, output int n);
        n = 0;
        while ((sel ? xv_l : xv_m) && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (xv_m) begin
            if (q_m.size() == 0) check_eq("m_unexpected_bit", q_m.size(), 1);
            else begin
                em = q_m.pop_front();
                check_eq("m_x", {31'd0, x_m}, {31'd0, em.x});
                check_eq("m_frame_start", {31'd0, fs_m}, {31'd0, em.fs});
            end
        end
        if (xv_l) begin
            if (q_l.size() == 0) check_eq("l_unexpected_bit", q_l.size(), 1);
            else begin
                el = q_l.pop_front();
                check_eq("l_x", {31'd0, x_l}, {31'd0, el.x});
                check_eq("l_frame_start", {31'd0, fs_l}, {31'd0, el.fs});
            end
        end
    end

    initial begin
        int w, n;
        // Reset state
        #1;
        check_eq("rst_x", {31'd0, x_m}, {31'd0, IDLE});
        check_eq("rst_x_valid", {31'd0, xv_m}, 0);
        check_eq("rst_frame_start", {31'd0, fs_m}, 0);
        check_eq("rst_busy", {31'd0, busy_m}, 0);
        check_eq("rst_ready", {31'd0, rdy_m}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready_after_m", {31'd0, rdy_m}, 1);
        check_eq("rst_ready_after_l", {31'd0, rdy_l}, 1);

        // Test 1: single word 8'hB0, detector hit one edge after cycle 4
        send(1'b0, 8'hB0, w);
        dv_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_eq("t1_x_valid", {31'd0, xv_m}, 1);
            check_eq("t1_det_hit", {31'd0, det_hit}, {31'd0, c == 5});
            @(negedge clk);
        end
        check_eq("t1_idle_x_valid", {31'd0, xv_m}, 0);
        check_eq("t1_idle_busy", {31'd0, busy_m}, 0);
        check_eq("t1_idle_x", {31'd0, x_m}, {31'd0, IDLE});

        // Test 2: back-to-back 8'hA5, 8'h3C
        send(1'b0, 8'hA5, w);
        send(1'b0, 8'h3C, w);
        dv_m = 1'b0;
        check_eq("t2_ready_full", {31'd0, rdy_m}, 0);
        check_eq("t2_busy", {31'd0, busy_m}, 1);
        count_run(1'b0, n);
        check_eq("t2_run", n, 15);
        check_eq("t2_busy_end", {31'd0, busy_m}, 0);

        // Test 3: three words offered continuously, third stalls
        send(1'b0, 8'h11, w);
        send(1'b0, 8'h22, w);
        send(1'b0, 8'h33, w);
        dv_m = 1'b0;
        check_eq("t3_stall_cycles", w, W - 1);
        count_run(1'b0, n);
        check_eq("t3_run", n, 15);

        // Bypass: next word offered exactly on the last bit with the buffer empty
        send(1'b0, 8'hC3, w);
        dv_m = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("byp_last_bit_valid", {31'd0, xv_m}, 1);
        send(1'b0, 8'h5A, w);
        dv_m = 1'b0;
        check_eq("byp_no_wait", w, 0);
        count_run(1'b0, n);
        check_eq("byp_run", n, 8);

        // Test 4: LSB-first 8'h0D gives the same stream as test 1
        send(1'b1, 8'h0D, w);
        dv_l = 1'b0;
        count_run(1'b1, n);
        check_eq("t4_run", n, 8);

        // Test 5: reset at bit 3 of 8'hFF with 8'h55 pending
        send(1'b0, 8'hFF, w);
        send(1'b0, 8'h55, w);
        dv_m = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t5_x", {31'd0, x_m}, {31'd0, IDLE});
        check_eq("t5_x_valid", {31'd0, xv_m}, 0);
        check_eq("t5_busy", {31'd0, busy_m}, 0);
        check_eq("t5_ready", {31'd0, rdy_m}, 0);
        q_m.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("t5_ready_after", {31'd0, rdy_m}, 1);
        check_eq("t5_busy_after", {31'd0, busy_m}, 0);
        send(1'b0, 8'h81, w);
        dv_m = 1'b0;
        count_run(1'b0, n);
        check_eq("t5_run", n, 8);

        // Test 6: idle for 20 cycles
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("t6_x", {31'd0, x_m}, {31'd0, IDLE});
            check_eq("t6_x_valid", {31'd0, xv_m}, 0);
            check_eq("t6_busy", {31'd0, busy_m}, 0);
            check_eq("t6_ready", {31'd0, rdy_m}, 1);
        end

        check_eq("final_queue_m", q_m.size(), 0);
        check_eq("final_queue_l", q_l.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
